// File: rtl/rgmii_tx_ddr_gen.sv
// rgmii_tx_ddr_gen
//   Turns a GMII byte stream into rising/falling-half pairs of RGMII data,
//   control and forwarded clock. The pairs feed ODDR primitives. Everything
//   runs in the 125 MHz transmit clock domain.
//   1000M : one byte per clk. Low nibble goes on the rising half, high nibble
//           on the falling half.
//   10/100: SDR nibbles. The forwarded clock period is N clk cycles, where
//           N = DIV_100 or DIV_10. Each nibble lasts one forwarded-clock
//           period, low nibble first. A byte is accepted every 2N cycles.
// Ports
//   clk, rst            : clock and synchronous active-high reset
//   speed               : 00 = 10M, 01 = 100M, 1x = 1000M
//   gmii_txd/_tx_en/_er : MAC byte, captured at the edge that ends a
//                         mac_clk_en cycle
//   mac_clk_en          : combinational byte-accept strobe
//   txc_q1/q2           : registered forwarded-clock pair (rise/fall half)
//   txd_q1/q2           : registered RGMII data pair
//   txctl_q1/q2         : registered RGMII control pair (en, en^er)
module rgmii_tx_ddr_gen #(
  parameter int DIV_100 = 5,
  parameter int DIV_10  = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] speed,
  input  logic [7:0] gmii_txd,
  input  logic       gmii_tx_en,
  input  logic       gmii_tx_er,
  output logic       mac_clk_en,
  output logic       txc_q1,
  output logic       txc_q2,
  output logic [3:0] txd_q1,
  output logic [3:0] txd_q2,
  output logic       txctl_q1,
  output logic       txctl_q2
);

  localparam int          CW    = $clog2(DIV_10);
  localparam logic [CW:0] N_100 = (CW+1)'(DIV_100);
  localparam logic [CW:0] N_10  = (CW+1)'(DIV_10);

  logic [1:0]    speed_r_q, speed_r_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ph_q, ph_d;
  logic [3:0]    hold_nib_q, hold_nib_d;
  logic          hold_en_q, hold_en_d;
  logic          hold_er_q, hold_er_d;
  logic          txc1_d, txc2_d;
  logic [3:0]    txd1_d, txd2_d;
  logic          txctl1_d, txctl2_d;

  logic          resync, gig, at_last;
  logic [CW:0]   n_w;
  logic [CW-1:0] n_m1;

  always_comb begin
    resync  = (speed != speed_r_q);
    gig     = speed_r_q[1];
    n_w     = speed_r_q[0] ? N_100 : N_10;
    n_m1    = CW'(n_w - 1'b1);
    at_last = (cnt_q == n_m1);
    // The strobe is combinational so the MAC sees it in the same cycle as
    // the capture edge. It is suppressed while a speed change is pending.
    mac_clk_en = !rst && !resync && (gig || (at_last && ph_q));

    speed_r_d  = speed_r_q;
    cnt_d      = cnt_q;
    ph_d       = ph_q;
    hold_nib_d = hold_nib_q;
    hold_en_d  = hold_en_q;
    hold_er_d  = hold_er_q;
    txc1_d     = txc_q1;
    txc2_d     = txc_q2;
    txd1_d     = txd_q1;
    txd2_d     = txd_q2;
    txctl1_d   = txctl_q1;
    txctl2_d   = txctl_q2;

    if (resync) begin
      // Adopt the new speed from a clean slate. A frame in flight is dropped.
      speed_r_d  = speed;
      cnt_d      = '0;
      ph_d       = 1'b0;
      hold_nib_d = '0;
      hold_en_d  = 1'b0;
      hold_er_d  = 1'b0;
      txc1_d     = 1'b0;
      txc2_d     = 1'b0;
      txd1_d     = '0;
      txd2_d     = '0;
      txctl1_d   = 1'b0;
      txctl2_d   = 1'b0;
    end else if (gig) begin
      cnt_d    = '0;
      ph_d     = 1'b0;
      txc1_d   = 1'b1;
      txc2_d   = 1'b0;
      txd1_d   = gmii_txd[3:0];
      txd2_d   = gmii_txd[7:4];
      txctl1_d = gmii_tx_en;
      txctl2_d = gmii_tx_en ^ gmii_tx_er;
    end else begin
      cnt_d = at_last ? '0 : cnt_q + CW'(1);
      ph_d  = ph_q ^ at_last;
      if (at_last && ph_q) begin
        // Capture edge: the low nibble goes out now, the high nibble waits.
        txd1_d     = gmii_txd[3:0];
        txd2_d     = gmii_txd[3:0];
        txctl1_d   = gmii_tx_en;
        txctl2_d   = gmii_tx_en ^ gmii_tx_er;
        hold_nib_d = gmii_txd[7:4];
        hold_en_d  = gmii_tx_en;
        hold_er_d  = gmii_tx_er;
      end else if (at_last) begin
        txd1_d   = hold_nib_q;
        txd2_d   = hold_nib_q;
        txctl1_d = hold_en_q;
        txctl2_d = hold_en_q ^ hold_er_q;
      end
      // The forwarded clock is computed from the next count k, so the
      // registered value lines up with the cycle in which cnt == k. Each clk
      // cycle holds two half-cycles (2k, 2k+1). The clock is high while the
      // half-cycle index is below N. This gives an exact 50% duty even for
      // odd N.
      txc1_d = ({cnt_d, 1'b0} < n_w);
      txc2_d = ({cnt_d, 1'b1} < n_w);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      speed_r_q  <= 2'b10;
      cnt_q      <= '0;
      ph_q       <= 1'b0;
      hold_nib_q <= '0;
      hold_en_q  <= 1'b0;
      hold_er_q  <= 1'b0;
      txc_q1     <= 1'b0;
      txc_q2     <= 1'b0;
      txd_q1     <= '0;
      txd_q2     <= '0;
      txctl_q1   <= 1'b0;
      txctl_q2   <= 1'b0;
    end else begin
      speed_r_q  <= speed_r_d;
      cnt_q      <= cnt_d;
      ph_q       <= ph_d;
      hold_nib_q <= hold_nib_d;
      hold_en_q  <= hold_en_d;
      hold_er_q  <= hold_er_d;
      txc_q1     <= txc1_d;
      txc_q2     <= txc2_d;
      txd_q1     <= txd1_d;
      txd_q2     <= txd2_d;
      txctl_q1   <= txctl1_d;
      txctl_q2   <= txctl2_d;
    end
  end

endmodule

// File: tb/tb_rgmii_tx_ddr_gen.sv
// Directed bench for rgmii_tx_ddr_gen (DIV_100 = 5, DIV_10 = 50).
// Expected output records are queued when a byte is driven. Each one is
// popped and compared on the following cycles.
module tb_rgmii_tx_ddr_gen;

  typedef struct packed {
    logic       c1;
    logic       c2;
    logic [3:0] d1;
    logic [3:0] d2;
    logic       t1;
    logic       t2;
  } out_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] speed;
  logic [7:0] gmii_txd;
  logic       gmii_tx_en, gmii_tx_er;
  logic       mac_clk_en, txc_q1, txc_q2, txctl_q1, txctl_q2;
  logic [3:0] txd_q1, txd_q2;

  int   checks = 0;
  int   errors = 0;
  out_t exp_q[$];
  logic [1:0] txc100 [0:4];

  rgmii_tx_ddr_gen #(.DIV_100(5), .DIV_10(50)) dut (
    .clk(clk), .rst(rst), .speed(speed),
    .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er),
    .mac_clk_en(mac_clk_en),
    .txc_q1(txc_q1), .txc_q2(txc_q2),
    .txd_q1(txd_q1), .txd_q2(txd_q2),
    .txctl_q1(txctl_q1), .txctl_q2(txctl_q2)
  );

  always #4 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic out_t mk(logic c1, logic c2, logic [3:0] d1, logic [3:0] d2,
                              logic t1, logic t2);
    out_t o;
    o.c1 = c1; o.c2 = c2; o.d1 = d1; o.d2 = d2; o.t1 = t1; o.t2 = t2;
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check(string tag);
    out_t e, o;
    o = mk(txc_q1, txc_q2, txd_q1, txd_q2, txctl_q1, txctl_q2);
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed=%h expected=<scoreboard empty>", tag, o);
    end else begin
      e = exp_q.pop_front();
      assert (o === e) else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", tag, o, e);
      end
    end
  endtask

  task automatic check_en(string tag, logic exp);
    checks++;
    assert (mac_clk_en === exp) else begin
      errors++;
      $error("FAIL %s: mac_clk_en observed=%b expected=%b", tag, mac_clk_en, exp);
    end
  endtask

  task automatic check_int(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Ten records of a 100M byte: five cycles of low nibble, then five of high
  // nibble. Each nibble carries one forwarded-clock period.
  task automatic push_byte100(logic [3:0] lo, logic [3:0] hi, logic t1, logic t2);
    for (int j = 0; j < 10; j++)
      exp_q.push_back(mk(txc100[j%5][1], txc100[j%5][0],
                         (j < 5) ? lo : hi, (j < 5) ? lo : hi, t1, t2));
  endtask

  task automatic drive(logic [7:0] d, logic en, logic er);
    gmii_txd = d; gmii_tx_en = en; gmii_tx_er = er;
  endtask

  // Count the cycles until the strobe appears, starting from the current cycle.
  task automatic wait_strobe(int bound, output int n);
    n = 0;
    #1;
    while (mac_clk_en !== 1'b1 && n < bound) begin
      tick();
      #1;
      n++;
    end
  endtask

  initial begin
    int n;
    int hi;
    txc100[0] = 2'b11; txc100[1] = 2'b11; txc100[2] = 2'b10;
    txc100[3] = 2'b00; txc100[4] = 2'b00;

    rst = 1'b1; speed = 2'b10; drive(8'h00, 1'b0, 1'b0);
    tick(); tick();
    exp_q.push_back(mk(0, 0, 4'h0, 4'h0, 0, 0));
    pop_check("reset_out");
    #1 check_en("en_in_reset", 1'b0);

    // ---- gigabit passthrough ----
    rst = 1'b0; drive(8'h12, 1'b1, 1'b0);
    #1 check_en("gig_first_strobe", 1'b1);
    exp_q.push_back(mk(1, 0, 4'h2, 4'h1, 1, 1));
    tick(); pop_check("gig_12");
    drive(8'h34, 1'b1, 1'b0); exp_q.push_back(mk(1, 0, 4'h4, 4'h3, 1, 1));
    #1 check_en("gig_en", 1'b1);
    tick(); pop_check("gig_34");
    drive(8'hFF, 1'b1, 1'b1); exp_q.push_back(mk(1, 0, 4'hF, 4'hF, 1, 0));
    tick(); pop_check("gig_en_er");
    drive(8'h00, 1'b0, 1'b1); exp_q.push_back(mk(1, 0, 4'h0, 4'h0, 0, 1));
    tick(); pop_check("gig_er_only");
    drive(8'h00, 1'b0, 1'b0);

    // ---- switch to 100M ----
    speed = 2'b01;
    #1 check_en("resync_en_100m", 1'b0);
    exp_q.push_back(mk(0, 0, 4'h0, 4'h0, 0, 0));
    tick(); pop_check("resync_out_100m");
    wait_strobe(200, n);
    check_int("first_strobe_100m", n, 9);

    drive(8'hA5, 1'b1, 1'b0);
    push_byte100(4'h5, 4'hA, 1'b1, 1'b1);
    for (int j = 0; j < 10; j++) begin
      tick(); pop_check("nib_100m");
      if (j == 9) drive(8'h3C, 1'b1, 1'b0);
      else        drive(8'h00, 1'b0, 1'b0);
      #1 check_en("spacing_100m", j == 9);
    end

    // ---- reset at 100M with cnt = 3, ph = 1 ----
    push_byte100(4'hC, 4'h3, 1'b1, 1'b1);
    for (int j = 0; j < 9; j++) begin
      tick(); pop_check("nib_pre_rst");
      drive(8'h00, 1'b0, 1'b0);
    end
    exp_q.delete();
    rst = 1'b1;
    #1 check_en("en_rst_asserted", 1'b0);
    exp_q.push_back(mk(0, 0, 4'h0, 4'h0, 0, 0));
    tick(); pop_check("rst_out_100m");
    #1 check_en("en_during_rst", 1'b0);
    // Reset returns speed_r to gigabit, so the first cycle after release is
    // a resync back to 100M. The 2N-1 count starts once that cycle is done.
    rst = 1'b0;
    #1 check_en("en_resync_after_rst", 1'b0);
    tick();
    wait_strobe(200, n);
    check_int("first_strobe_after_rst", n, 9);

    // ---- mid-byte change 100M -> 1000M ----
    drive(8'h3C, 1'b1, 1'b0);
    push_byte100(4'hC, 4'h3, 1'b1, 1'b1);
    for (int j = 0; j < 7; j++) begin
      tick(); pop_check("nib_mid");
      drive(8'h00, 1'b0, 1'b0);
    end
    exp_q.delete();
    speed = 2'b10; drive(8'h77, 1'b1, 1'b0);
    #1 check_en("resync_en_gig", 1'b0);
    exp_q.push_back(mk(0, 0, 4'h0, 4'h0, 0, 0));
    tick(); pop_check("resync_out_gig");
    drive(8'h5A, 1'b1, 1'b0);
    #1 check_en("gig_after_resync_en", 1'b1);
    exp_q.push_back(mk(1, 0, 4'hA, 4'h5, 1, 1));
    tick(); pop_check("gig_no_stale");

    // ---- 10M ----
    speed = 2'b00; drive(8'h00, 1'b0, 1'b0);
    #1 check_en("resync_en_10m", 1'b0);
    exp_q.push_back(mk(0, 0, 4'h0, 4'h0, 0, 0));
    tick(); pop_check("resync_out_10m");
    wait_strobe(300, n);
    check_int("first_strobe_10m", n, 99);

    drive(8'h96, 1'b1, 1'b0);
    for (int j = 0; j < 100; j++)
      exp_q.push_back(mk((j % 50) < 25, (j % 50) < 25,
                         (j < 50) ? 4'h6 : 4'h9, (j < 50) ? 4'h6 : 4'h9, 1, 1));
    hi = 0;
    for (int j = 0; j < 100; j++) begin
      tick();
      if (j < 50) hi += int'(txc_q1) + int'(txc_q2);
      pop_check("nib_10m");
      drive(8'h00, 1'b0, 1'b0);
      #1 check_en("spacing_10m", j == 99);
    end
    check_int("txc_high_10m", hi, 50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
